mult_div_unit: RTL

Multicycle signed multiply/divide unit for the MIPS datapath, sitting directly downstream of the control unit. It executes MULT and DIV on operands taken from the A/B registers and writes the HI/LO registers that MFHI/MFLO read. The control unit starts an operation with a one-cycle `start` pulse, then waits in its MULT/DIV state until `done` (or `div_zero`) before returning to fetch.

---
 rtl/mult_div_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module   : mult_div_unit
// Purpose  : Multicycle signed MULT/DIV (radix-2, 32 iterations) writing HI/LO.
//            Optional macro MULTDIV_DIVZERO_EN rejects DIV by zero up front.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_div_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done,
   output logic        div_zero
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_FIX  = 2'd3
   } state_t;

   state_t      r_state, w_next;
   logic        r_op, r_sa, r_sb, r_done;
   logic [31:0] r_a, r_b, r_hi, r_lo;
   logic [63:0] r_acc;
   logic [4:0]  r_cnt;
   logic        w_dz_reject;

`ifdef MULTDIV_DIVZERO_EN
   logic        r_div_zero;
   assign w_dz_reject = op && (b == 32'd0);
   assign div_zero    = r_div_zero;
`else
   assign w_dz_reject = 1'b0;
   assign div_zero    = 1'b0;
`endif

   // Magnitudes of the latched operands (0x80000000 stays 0x80000000 unsigned)
   logic [31:0] w_abs_a, w_abs_b;
   assign w_abs_a = r_a[31] ? (32'd0 - r_a) : r_a;
   assign w_abs_b = r_b[31] ? (32'd0 - r_b) : r_b;

   // Shift-add step: multiplier sits in the low half and shifts out LSB first
   logic [32:0] w_mul_sum;
   logic [63:0] w_mul_step;
   assign w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, r_a};
   assign w_mul_step = r_acc[0] ? {w_mul_sum, r_acc[31:1]} : {1'b0, r_acc[63:1]};

   // Restoring step: partial remainder high, quotient bits enter at the LSB
   logic [63:0] w_div_sh;
   logic [32:0] w_div_trial;
   logic [63:0] w_div_step;
   assign w_div_sh    = {r_acc[62:0], 1'b0};
   assign w_div_trial = {1'b0, w_div_sh[63:32]} - {1'b0, r_b};
   assign w_div_step  = w_div_trial[32] ? w_div_sh
                                        : {w_div_trial[31:0], w_div_sh[31:1], 1'b1};

   logic [63:0] w_prod;
   logic [31:0] w_quo, w_rem;
   assign w_prod = (r_sa ^ r_sb) ? (64'd0 - r_acc) : r_acc;
   assign w_quo  = (r_sa ^ r_sb) ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
   assign w_rem  = r_sa ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (start && !w_dz_reject) w_next = S_LOAD;
         S_LOAD: w_next = S_RUN;
         S_RUN:  if (r_cnt == 5'd31) w_next = S_FIX;
         S_FIX:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_op   <= 1'b0;
         r_sa   <= 1'b0;
         r_sb   <= 1'b0;
         r_a    <= 32'd0;
         r_b    <= 32'd0;
         r_acc  <= 64'd0;
         r_cnt  <= 5'd0;
         r_hi   <= 32'd0;
         r_lo   <= 32'd0;
         r_done <= 1'b0;
`ifdef MULTDIV_DIVZERO_EN
         r_div_zero <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
`ifdef MULTDIV_DIVZERO_EN
         r_div_zero <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (w_dz_reject) begin
                     r_done <= 1'b1;
`ifdef MULTDIV_DIVZERO_EN
                     r_div_zero <= 1'b1;
`endif
                  end else begin
                     r_a  <= a;
                     r_b  <= b;
                     r_op <= op;
                  end
               end
            end
            S_LOAD: begin
               r_sa  <= r_a[31];
               r_sb  <= r_b[31];
               r_a   <= w_abs_a;
               r_b   <= w_abs_b;
               r_acc <= r_op ? {32'd0, w_abs_a} : {32'd0, w_abs_b};
               r_cnt <= 5'd0;
            end
            S_RUN: begin
               r_acc <= r_op ? w_div_step : w_mul_step;
               r_cnt <= r_cnt + 5'd1;
            end
            S_FIX: begin
               if (r_op) begin
                  r_hi <= w_rem;
                  r_lo <= w_quo;
               end else begin
                  r_hi <= w_prod[63:32];
                  r_lo <= w_prod[31:0];
               end
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign hi   = r_hi;
   assign lo   = r_lo;
   assign done = r_done;
   assign busy = (r_state != S_IDLE);

endmodule

`default_nettype wire
